// File: rtl/mmu_sequencer_if.sv
// ============================================================================
// Module      : mmu_sequencer_if
// Description : Command/strobe bundle between the host side and the matrix
//               multiply sequencer.
//               master : host side (drives start/abort, observes strobes)
//               slave  : sequencer side (samples start/abort, drives strobes)
// Signals     : start, abort                          host -> sequencer
//               load_weight, setup_clear, setup_valid,
//               capture, busy, done, op_count[7:0]    sequencer -> host/datapath
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mmu_sequencer_if;
  logic       start;
  logic       abort;
  logic       load_weight;
  logic       setup_clear;
  logic       setup_valid;
  logic       capture;
  logic       busy;
  logic       done;
  logic [7:0] op_count;

  modport master (
    output start,
    output abort,
    input  load_weight,
    input  setup_clear,
    input  setup_valid,
    input  capture,
    input  busy,
    input  done,
    input  op_count
  );

  modport slave (
    input  start,
    input  abort,
    output load_weight,
    output setup_clear,
    output setup_valid,
    output capture,
    output busy,
    output done,
    output op_count
  );
endinterface

`default_nettype wire

// File: rtl/mmu_sequencer.sv
// ============================================================================
// Module      : mmu_sequencer
// Description : Control FSM for the NxN systolic matrix-multiply unit. Runs
//               one multiply per accepted start: weight load + skew-buffer
//               clear, activation feed, pipeline drain, completion report.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous, active-high
//               bus    - mmu_sequencer_if.slave
//                        start/abort in; load_weight, setup_clear,
//                        setup_valid, capture, busy, done, op_count[7:0] out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_sequencer #(
  parameter int N            = 2,
  parameter int FEED_CYCLES  = N + 1,
  parameter int DRAIN_CYCLES = N + 1,
  parameter int CNT_W        = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mmu_sequencer_if.slave     bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LOAD  = 3'd1;
  localparam logic [2:0] c_FEED  = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam logic [CNT_W-1:0] c_FEED_LAST  = CNT_W'(FEED_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [7:0]       ops_q,   ops_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
    end
  end

  // Next-state logic. Abort is only honoured while a multiply is actually
  // in flight (LOAD/FEED/DRAIN); in IDLE start therefore always wins, and a
  // multiply that has reached DONE always completes and counts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ops_d   = ops_q;
    case (state_q)
      c_IDLE: begin
        if (bus.start) begin
          state_d = c_LOAD;
          cnt_d   = '0;
        end
      end
      c_LOAD: begin
        state_d = bus.abort ? c_IDLE : c_FEED;
        cnt_d   = '0;
      end
      c_FEED: begin
        if (bus.abort) begin
          state_d = c_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_FEED_LAST) begin
          state_d = c_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      c_DRAIN: begin
        if (bus.abort) begin
          state_d = c_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == c_DRAIN_LAST) begin
          state_d = c_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      c_DONE: begin
        state_d = c_IDLE;
        cnt_d   = '0;
        ops_d   = ops_q + 8'd1;
      end
      default: begin
        state_d = c_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs, decoded only from registered state and counter so that
  // reset forces every strobe low immediately and start/abort never reach
  // an output combinationally.
  always_comb begin
    bus.load_weight = 1'b0;
    bus.setup_clear = 1'b0;
    bus.setup_valid = 1'b0;
    bus.capture     = 1'b0;
    bus.busy        = 1'b0;
    bus.done        = 1'b0;
    case (state_q)
      c_LOAD: begin
        bus.load_weight = 1'b1;
        bus.setup_clear = 1'b1;
        bus.busy        = 1'b1;
      end
      c_FEED: begin
        bus.setup_valid = 1'b1;
        bus.busy        = 1'b1;
      end
      c_DRAIN: begin
        // Last drain cycle: final partial sum has left the array.
        bus.capture     = (cnt_q == c_DRAIN_LAST);
        bus.busy        = 1'b1;
      end
      c_DONE: begin
        bus.done        = 1'b1;
        bus.busy        = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.op_count = ops_q;

endmodule

`default_nettype wire
